// File: rtl/seg7_out.sv
// seg7_out: takes a 14-bit binary value with a one-cycle load strobe, converts
// it to four BCD digits with one double-dabble iteration per clock, and drives
// four active-low 7-segment displays.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   VAL       in   [13:0] unsigned value, sampled on an accepted load
//   LOAD      in   one-cycle strobe requesting display of VAL
//   BLANK_LZ  in   1 = blank leading zero digits, sampled with VAL
//   HEX0..3   out  [6:0] active-low segments {g,f,e,d,c,b,a}, ones..thousands
//   BUSY      out  conversion in progress
//   OVF       out  last displayed value exceeded 9999
module seg7_out #(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic             CLOCK_50,
   input  logic             RST,
   input  logic [WIDTH-1:0] VAL,
   input  logic             LOAD,
   input  logic             BLANK_LZ,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1,
   output logic [6:0]       HEX2,
   output logic [6:0]       HEX3,
   output logic             BUSY,
   output logic             OVF
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   typedef enum logic [1:0] {IDLE, CONV, UPDT} state_t;

   state_t               state;
   logic [WIDTH-1:0]     bin;
   logic [4*DIGITS-1:0]  bcd;
   logic [3:0]           cnt;
   logic                 blank_f;
   logic                 ovf_next;
   logic                 pending;
   logic [WIDTH-1:0]     pend_val;
   logic                 pend_blank;

   logic [4*DIGITS-1:0]  bcd_adj;
   logic [4*DIGITS-1:0]  bcd_n;
   logic [WIDTH-1:0]     bin_n;
   logic [WIDTH-1:0]     start_val;
   logic                 start_blank;
   logic [6:0]           hex0_n, hex1_n, hex2_n, hex3_n;
   logic                 lz3, lz2, lz1;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift
   // {bcd, bin} left by one.
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_n = {bcd_adj[4*DIGITS-2:0], bin[WIDTH-1]};
      bin_n = {bin[WIDTH-2:0], 1'b0};
   end

   // A LOAD arriving on the UPDT edge is newer than any pending entry.
   always_comb begin
      start_val   = VAL;
      start_blank = BLANK_LZ;
      if (state == UPDT && !LOAD) begin
         start_val   = pend_val;
         start_blank = pend_blank;
      end
   end

   always_comb begin
      lz3 = blank_f && (bcd[15:12] == 4'd0);
      lz2 = lz3 && (bcd[11:8] == 4'd0);
      lz1 = lz2 && (bcd[7:4] == 4'd0);
      if (ovf_next) begin
         hex3_n = SEG_DASH;
         hex2_n = SEG_DASH;
         hex1_n = SEG_DASH;
         hex0_n = SEG_DASH;
      end else begin
         hex3_n = lz3 ? SEG_BLANK : seg(bcd[15:12]);
         hex2_n = lz2 ? SEG_BLANK : seg(bcd[11:8]);
         hex1_n = lz1 ? SEG_BLANK : seg(bcd[7:4]);
         hex0_n = seg(bcd[3:0]);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         state      <= IDLE;
         bin        <= '0;
         bcd        <= '0;
         cnt        <= '0;
         blank_f    <= 1'b0;
         ovf_next   <= 1'b0;
         pending    <= 1'b0;
         pend_val   <= '0;
         pend_blank <= 1'b0;
         HEX0       <= SEG_ZERO;
         HEX1       <= SEG_ZERO;
         HEX2       <= SEG_ZERO;
         HEX3       <= SEG_ZERO;
         BUSY       <= 1'b0;
         OVF        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (LOAD) begin
                  bin      <= start_val;
                  blank_f  <= start_blank;
                  ovf_next <= (start_val > 14'd9999);
                  bcd      <= '0;
                  cnt      <= '0;
                  state    <= CONV;
                  BUSY     <= 1'b1;
               end
            end
            CONV: begin
               bcd <= bcd_n;
               bin <= bin_n;
               if (cnt == 4'd13)
                  state <= UPDT;
               else
                  cnt <= cnt + 4'd1;
               if (LOAD) begin
                  pending    <= 1'b1;
                  pend_val   <= VAL;
                  pend_blank <= BLANK_LZ;
               end
            end
            UPDT: begin
               HEX0 <= hex0_n;
               HEX1 <= hex1_n;
               HEX2 <= hex2_n;
               HEX3 <= hex3_n;
               OVF  <= ovf_next;
               if (LOAD || pending) begin
                  bin      <= start_val;
                  blank_f  <= start_blank;
                  ovf_next <= (start_val > 14'd9999);
                  bcd      <= '0;
                  cnt      <= '0;
                  pending  <= 1'b0;
                  state    <= CONV;
                  BUSY     <= 1'b1;
               end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_out.sv
module tb_seg7_out;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

   logic        CLOCK_50 = 1'b0;
   logic        RST = 1'b1;
   logic [13:0] VAL = '0;
   logic        LOAD = 1'b0;
   logic        BLANK_LZ = 1'b0;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;
   logic        BUSY, OVF;

   int checks = 0;
   int errors = 0;

   // expected display contents (bench model)
   logic [6:0] e3, e2, e1, e0;
   logic       eovf;

   typedef struct {
      logic [13:0] val;
      logic        blank;
      logic [6:0]  h3, h2, h1, h0;
      logic        ovf;
   } vec_t;

   vec_t vecs[10];

   seg7_out #(.WIDTH(14), .DIGITS(4)) dut (
      .CLOCK_50(CLOCK_50), .RST(RST), .VAL(VAL), .LOAD(LOAD), .BLANK_LZ(BLANK_LZ),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .BUSY(BUSY), .OVF(OVF)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic check_disp(input string name);
      check({name, ".HEX3"}, 32'(HEX3), 32'(e3));
      check({name, ".HEX2"}, 32'(HEX2), 32'(e2));
      check({name, ".HEX1"}, 32'(HEX1), 32'(e1));
      check({name, ".HEX0"}, 32'(HEX0), 32'(e0));
      check({name, ".OVF"},  32'(OVF),  32'(eovf));
   endtask

   task automatic set_exp(input logic [6:0] h3, h2, h1, h0, input logic ovf);
      e3 = h3; e2 = h2; e1 = h1; e0 = h0; eovf = ovf;
   endtask

   // Apply LOAD for exactly one edge (edge k); returns at negedge after k.
   task automatic load(input logic [13:0] v, input logic b);
      VAL = v; BLANK_LZ = b; LOAD = 1'b1;
      step();
      LOAD = 1'b0;
   endtask

   // n edges during which BUSY must stay 1 and the display must not change.
   task automatic hold(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check({name, ".busy"}, 32'(BUSY), 32'd1);
         check_disp({name, ".hold"});
      end
   endtask

   initial begin
      vecs[0] = '{14'd1234,  1'b0, S1, S2, S3, S4, 1'b0};
      vecs[1] = '{14'd7,     1'b1, SB, SB, SB, S7, 1'b0};
      vecs[2] = '{14'd0,     1'b1, SB, SB, SB, S0, 1'b0};
      vecs[3] = '{14'd10000, 1'b0, SD, SD, SD, SD, 1'b1};
      vecs[4] = '{14'd9999,  1'b0, S9, S9, S9, S9, 1'b0};
      vecs[5] = '{14'd42,    1'b1, SB, SB, S4, S2, 1'b0};
      vecs[6] = '{14'd105,   1'b1, SB, S1, S0, S5, 1'b0};
      vecs[7] = '{14'd16383, 1'b1, SD, SD, SD, SD, 1'b1};
      vecs[8] = '{14'd9000,  1'b1, S9, S0, S0, S0, 1'b0};
      vecs[9] = '{14'd56,    1'b0, S0, S0, S5, S6, 1'b0};

      // reset
      @(negedge CLOCK_50);
      step(); step();
      RST = 1'b0;
      set_exp(S0, S0, S0, S0, 1'b0);
      check_disp("reset");
      check("reset.busy", 32'(BUSY), 32'd0);
      step();
      check("idle.busy", 32'(BUSY), 32'd0);

      // table: constant latency, display changes only at edge k+15
      for (int i = 0; i < 10; i++) begin
         load(vecs[i].val, vecs[i].blank);
         check($sformatf("v%0d.busy_k", i), 32'(BUSY), 32'd1);
         check_disp($sformatf("v%0d.k", i));
         hold($sformatf("v%0d", i), 14);
         step();
         set_exp(vecs[i].h3, vecs[i].h2, vecs[i].h1, vecs[i].h0, vecs[i].ovf);
         check_disp($sformatf("v%0d.upd", i));
         check($sformatf("v%0d.busy_done", i), 32'(BUSY), 32'd0);
         step();
      end

      // back-to-back: 42 at k, 500 at k+3, 999 at k+5 -> 42 then 999
      load(14'd42, 1'b0);                 // edge k
      hold("bb.a", 2);                    // k+1, k+2
      load(14'd500, 1'b0);                // k+3
      check("bb.busy3", 32'(BUSY), 32'd1);
      hold("bb.b", 1);                    // k+4
      load(14'd999, 1'b0);                // k+5
      hold("bb.c", 9);                    // k+6..k+14
      step();                             // k+15
      set_exp(S0, S0, S4, S2, 1'b0);
      check_disp("bb.first");
      check("bb.busy15", 32'(BUSY), 32'd1);
      hold("bb.d", 14);                   // k+16..k+29
      step();                             // k+30
      set_exp(S0, S9, S9, S9, 1'b0);
      check_disp("bb.second");
      check("bb.busy30", 32'(BUSY), 32'd0);
      step();

      // overflow set, then reset mid-conversion of 8888
      load(14'd12000, 1'b0);
      hold("ovr", 14);
      step();
      set_exp(SD, SD, SD, SD, 1'b1);
      check_disp("ovr.upd");
      load(14'd8888, 1'b0);               // k
      hold("rst", 6);                     // k+1..k+6
      RST = 1'b1;
      step();                             // k+7
      RST = 1'b0;
      set_exp(S0, S0, S0, S0, 1'b0);
      check_disp("rst.after");
      check("rst.busy", 32'(BUSY), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("rst.idle_busy", 32'(BUSY), 32'd0);
         check_disp("rst.idle");
      end

      // LOAD on the UPDT edge of a prior conversion
      load(14'd1234, 1'b0);               // k
      hold("up.a", 14);                   // k+1..k+14
      load(14'd5678, 1'b0);               // k+15 (UPDT edge)
      set_exp(S1, S2, S3, S4, 1'b0);
      check_disp("up.first");
      check("up.busy15", 32'(BUSY), 32'd1);
      hold("up.b", 14);
      step();
      set_exp(S5, S6, S7, S8, 1'b0);
      check_disp("up.second");
      check("up.busy_done", 32'(BUSY), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
